input_ram_loader: RTL and testbench

Stream-to-RAM write engine that fills the 1024 x 8 input feature buffer before a SqueezeNet layer runs. It accepts bytes on a valid/ready stream from the host/DMA side and issues one registered write per accepted byte into the buffer's write port, starting at a programmable base address. It pulses `done` once the last write has been issued, so the compute datapath can begin reading the buffer.

---
 rtl/input_ram_loader.sv | 94 +++++++++
 tb/tb_input_ram_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/input_ram_loader.sv
// input_ram_loader: accepts a byte stream on a valid/ready port and writes
// each accepted beat into the input feature buffer at consecutive addresses
// starting from a latched base. Pulses done one cycle after the final write.
//
// state | meaning
// IDLE  | waiting for start; s_ready low
// LOAD  | accepting beats, one registered write per accepted beat
// DRAIN | last write on the RAM port, no further beats accepted
// DONE  | one-cycle completion pulse
module input_ram_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  // Buffer depth; longer requests are clamped to this so each address is
  // written at most once per load.
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   eff_len;
  logic [ADDR_WIDTH:0]   count_inc;
  logic                  accept;

  assign eff_len   = (length > MAX_LEN) ? MAX_LEN : length;
  assign accept    = (state_q == LOAD) && s_valid;
  assign count_inc = count + 1'b1;

  assign s_ready = (state_q == LOAD);
  assign busy    = (state_q == LOAD) || (state_q == DRAIN);
  assign done    = (state_q == DONE);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (length == '0) ? DONE : LOAD;
      LOAD:  if (accept && (count_inc == len_q)) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, beat counter, address pointer and registered RAM write port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      len_q     <= '0;
      addr_q    <= '0;
      count     <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= accept;
      if ((state_q == IDLE) && start) begin
        len_q  <= eff_len;
        addr_q <= base_addr;
        count  <= '0;
      end
      if (accept) begin
        ram_addr  <= addr_q;
        ram_wdata <= s_data;
        addr_q    <= addr_q + 1'b1;
        count     <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_input_ram_loader.sv
// Directed testbench for input_ram_loader. Stimulus pushes the expected
// (address, data) of every write into a queue; a monitor pops and compares
// whenever the DUT asserts ram_we. Timing of done/busy/s_ready is checked inline.
module tb_input_ram_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] length = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, ram_we, busy, done;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [10:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];

  input_ram_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
    .length(length), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .count(count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write", ram_addr, ram_wdata);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("write_addr", int'(ram_addr), int'(e[17:8]));
        chk("write_data", int'(ram_wdata), int'(e[7:0]));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive start for one sampling edge; returns in cycle 1.
  task automatic do_start(input int b, input int len);
    start = 1'b1;
    base_addr = 10'(b);
    length = 11'(len);
    tick();
    start = 1'b0;
  endtask

  // Drive n back-to-back beats; optionally a 2-cycle valid gap after beat index gap_after.
  task automatic feed(input int n, input int d0, input int gap_after, input int b);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data = 8'((d0 + i) & 255);
      exp_q.push_back({10'((b + i) % 1024), 8'((d0 + i) & 255)});
      tick();
      chk("we_after_accept", int'(ram_we), 1);
      if (i == gap_after) begin
        s_valid = 1'b0;
        s_data = 8'hEE;
        tick();
        chk("gap_no_we_1", int'(ram_we), 0);
        tick();
        chk("gap_no_we_2", int'(ram_we), 0);
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    // Reset held for 2 cycles with start and s_valid active.
    start = 1'b1;
    s_valid = 1'b1;
    length = 11'd4;
    tick();
    tick();
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_wdata", int'(ram_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    Reset = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    tick();

    // Basic load: 4 beats from base 0, writes in cycles 2..5, done in cycle 6.
    do_start(0, 4);
    chk("basic_s_ready_c1", int'(s_ready), 1);
    chk("basic_busy_c1", int'(busy), 1);
    feed(4, 1, -1, 0);
    chk("basic_drain_busy", int'(busy), 1);
    chk("basic_drain_s_ready", int'(s_ready), 0);
    tick();
    chk("basic_done", int'(done), 1);
    chk("basic_done_busy", int'(busy), 0);
    chk("basic_count", int'(count), 4);
    tick();
    chk("basic_done_pulse_end", int'(done), 0);
    chk("basic_count_hold", int'(count), 4);

    // Wrap with backpressure: 1022,1023,0,1, gap after second beat.
    do_start(1022, 4);
    feed(4, 8'h30, 1, 1022);
    chk("wrap_no_done_drain", int'(done), 0);
    tick();
    chk("wrap_done", int'(done), 1);
    chk("wrap_count", int'(count), 4);
    tick();

    // Zero length: done in cycle 1, nothing else moves.
    do_start(5, 0);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    chk("zero_s_ready", int'(s_ready), 0);
    chk("zero_ram_we", int'(ram_we), 0);
    chk("zero_count", int'(count), 0);
    tick();
    chk("zero_done_end", int'(done), 0);

    // Ignored start during LOAD, DRAIN and DONE.
    do_start(100, 3);
    start = 1'b1;
    base_addr = 10'd500;
    feed(1, 8'h50, -1, 100);
    start = 1'b0;
    feed(2, 8'h51, -1, 101);
    start = 1'b1;
    base_addr = 10'd500;
    chk("ign_drain_busy", int'(busy), 1);
    tick();
    chk("ign_done", int'(done), 1);
    chk("ign_count", int'(count), 3);
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    chk("ign_idle_busy", int'(busy), 0);
    tick();
    chk("ign_no_reload_busy", int'(busy), 0);
    chk("ign_no_reload_ready", int'(s_ready), 0);
    s_valid = 1'b0;
    tick();

    // Mid-load reset after 2 of 4 beats.
    do_start(16, 4);
    feed(2, 8'h70, -1, 16);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_s_ready", int'(s_ready), 0);
    chk("mid_rst_ram_we", int'(ram_we), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_done", int'(done), 0);
    tick();
    chk("mid_rst_no_done", int'(done), 0);
    do_start(32, 3);
    feed(3, 8'h90, -1, 32);
    tick();
    chk("after_rst_done", int'(done), 1);
    chk("after_rst_count", int'(count), 3);
    tick();

    // Clamped length: 2000 requested, 1024 writes covering every address once.
    do_start(300, 2000);
    feed(1024, 0, -1, 300);
    chk("clamp_drain_busy", int'(busy), 1);
    tick();
    chk("clamp_done", int'(done), 1);
    chk("clamp_count", int'(count), 1024);
    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
